// File: rtl/ct_ifu_icache_tag_array_sweep.sv
// I-cache tag array (SETS x WAYS {valid,tag} fields plus a per-set fifo bit) with
// per-field write enables, registered read data and a one-set-per-cycle invalidate-all sweep.
module ct_ifu_icache_tag_array_sweep #(
    parameter  int SETS  = 256,
    parameter  int WAYS  = 2,
    parameter  int TAG_W = 28,
    localparam int IDX_W = $clog2(SETS),
    localparam int DW    = WAYS * (TAG_W + 1) + 1
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst_b,
    input  logic              cp0_ifu_icg_en,
    input  logic              pad_yy_icg_scan_en,
    input  logic              ifu_icache_tag_cen_b,
    input  logic [WAYS:0]     ifu_icache_tag_wen,
    input  logic [IDX_W-1:0]  ifu_icache_index,
    input  logic [DW-1:0]     ifu_icache_tag_din,
    input  logic              ifu_icache_inv_req,
    output logic [DW-1:0]     icache_ifu_tag_dout,
    output logic              icache_ifu_inv_busy,
    output logic              icache_ifu_inv_done
);

    localparam int FW = TAG_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      dout_q, dout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [DW-1:0]      mem_q [SETS];

    logic               local_en_s;
    logic               clk_en_s;
    logic [DW-1:0]      field_mask_s;
    logic [DW-1:0]      clear_mask_s;
    logic               mem_we_s;
    logic [IDX_W-1:0]   mem_waddr_s;
    logic [DW-1:0]      mem_wdata_s;

    // Clock-gate enable: the gated domain (storage and dout) only advances when enabled.
    assign local_en_s = ~ifu_icache_tag_cen_b | busy_q | done_q;
    assign clk_en_s   = local_en_s | cp0_ifu_icg_en | pad_yy_icg_scan_en;

    // Field write mask from active-low enables, and the sweep mask that drops valid and fifo bits.
    always_comb begin
        field_mask_s = {DW{1'b0}};
        clear_mask_s = {DW{1'b1}};
        for (int f = 0; f < WAYS; f++) begin
            field_mask_s[f*FW +: FW]  = {FW{~ifu_icache_tag_wen[f]}};
            clear_mask_s[f*FW+TAG_W]  = 1'b0;
        end
        field_mask_s[DW-1] = ~ifu_icache_tag_wen[WAYS];
        clear_mask_s[DW-1] = 1'b0;
    end

    // Next-state, sweep counter, array write port and read-data selection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dout_d      = dout_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = ifu_icache_index;
        mem_wdata_s = mem_q[ifu_icache_index];
        case (state_q)
            ST_IDLE: begin
                if (!ifu_icache_tag_cen_b) begin
                    if (&ifu_icache_tag_wen) begin
                        dout_d = mem_q[ifu_icache_index];
                    end else begin
                        mem_we_s    = 1'b1;
                        mem_wdata_s = (mem_q[ifu_icache_index] & ~field_mask_s)
                                    | (ifu_icache_tag_din & field_mask_s);
                    end
                end else begin
                    dout_d = dout_q;
                end
                if (ifu_icache_inv_req) begin
                    state_d = ST_SWEEP;
                    cnt_d   = {IDX_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = cnt_q;
                mem_wdata_s = mem_q[cnt_q] & clear_mask_s;
                cnt_d       = cnt_q + IDX_W'(1);
                if (cnt_q == IDX_W'(SETS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SWEEP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {IDX_W{1'b0}};
            end
        endcase
        busy_d = (state_d == ST_SWEEP);
        done_d = (state_d == ST_DONE);
    end

    // Control state and status outputs.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= ST_IDLE;
            cnt_q   <= {IDX_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Read-data register in the gated domain.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            dout_q <= {DW{1'b0}};
        end else if (clk_en_s) begin
            dout_q <= dout_d;
        end else begin
            dout_q <= dout_q;
        end
    end

    // Tag storage; contents are deliberately not reset.
    always_ff @(posedge forever_cpuclk) begin
        if (clk_en_s && mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign icache_ifu_tag_dout = dout_q;
    assign icache_ifu_inv_busy = busy_q;
    assign icache_ifu_inv_done = done_q;

endmodule

// File: tb/tb_ct_ifu_icache_tag_array_sweep.sv
// Directed bench for ct_ifu_icache_tag_array_sweep: array model plus expected-read queue.
module tb_ct_ifu_icache_tag_array_sweep;

    localparam int SETS  = 256;
    localparam int WAYS  = 2;
    localparam int TAG_W = 28;
    localparam int FW    = TAG_W + 1;
    localparam int DW    = WAYS * FW + 1;
    localparam int IDX_W = 8;

    logic              clk;
    logic              rst_n;
    logic              icg_en;
    logic              scan_en;
    logic              cen_b;
    logic [WAYS:0]     wen;
    logic [IDX_W-1:0]  index;
    logic [DW-1:0]     din;
    logic              inv_req;
    logic [DW-1:0]     dout;
    logic              busy;
    logic              done;

    logic [DW-1:0]     model [SETS];
    logic [DW-1:0]     exp_q [$];
    logic [DW-1:0]     keep;
    int                n_tests;
    int                n_fail;

    ct_ifu_icache_tag_array_sweep #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) dut (
        .forever_cpuclk       (clk),
        .cpurst_b             (rst_n),
        .cp0_ifu_icg_en       (icg_en),
        .pad_yy_icg_scan_en   (scan_en),
        .ifu_icache_tag_cen_b (cen_b),
        .ifu_icache_tag_wen   (wen),
        .ifu_icache_index     (index),
        .ifu_icache_tag_din   (din),
        .ifu_icache_inv_req   (inv_req),
        .icache_ifu_tag_dout  (dout),
        .icache_ifu_inv_busy  (busy),
        .icache_ifu_inv_done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        cen_b   = 1'b1;
        wen     = 3'b111;
        inv_req = 1'b0;
    endtask

    function automatic logic [DW-1:0] wmask(input logic [WAYS:0] w);
        logic [DW-1:0] m;
        m = {DW{1'b0}};
        for (int f = 0; f < WAYS; f++) begin
            if (!w[f]) m[f*FW +: FW] = {FW{1'b1}};
        end
        if (!w[WAYS]) m[DW-1] = 1'b1;
        return m;
    endfunction

    function automatic logic [DW-1:0] rnd_word();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[DW-1:0];
    endfunction

    task automatic do_write(input logic [IDX_W-1:0] idx, input logic [WAYS:0] w,
                            input logic [DW-1:0] data);
        logic [DW-1:0] m;
        m = wmask(w);
        cen_b = 1'b0;
        wen   = w;
        index = idx;
        din   = data;
        model[idx] = (model[idx] & ~m) | (data & m);
        tick();
        idle_in();
    endtask

    task automatic do_read(input logic [IDX_W-1:0] idx, input string tag);
        cen_b = 1'b0;
        wen   = 3'b111;
        index = idx;
        exp_q.push_back(model[idx]);
        tick();
        idle_in();
        check(tag, 64'(dout), 64'(exp_q.pop_front()));
    endtask

    initial begin
        logic [DW-1:0] d0, d1, held;
        int cyc, busy_cnt, done_cyc;
        n_tests = 0;
        n_fail  = 0;
        keep = {DW{1'b1}};
        for (int k = 0; k < WAYS; k++) keep[k*FW+TAG_W] = 1'b0;
        keep[DW-1] = 1'b0;
        for (int i = 0; i < SETS; i++) model[i] = {DW{1'b0}};

        rst_n = 1'b0; icg_en = 1'b0; scan_en = 1'b0;
        index = '0; din = '0;
        idle_in();
        repeat (3) tick();
        check("reset_dout", 64'(dout), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        tick();

        // T1 full write then read
        d0 = rnd_word();
        do_write(8'd5, 3'b000, d0);
        do_read(8'd5, "t1_read5");
        do_write(8'd9, 3'b000, rnd_word());
        check("write_holds_dout", 64'(dout), 64'(d0));
        tick();
        check("idle_holds_dout", 64'(dout), 64'(d0));

        // T2 partial write: only way 1 field
        d0 = rnd_word();
        d1 = rnd_word();
        do_write(8'd7, 3'b000, d0);
        do_write(8'd7, 3'b101, d1);
        do_read(8'd7, "t2_partial");
        check("t2_indep", 64'(dout), 64'({d0[58], d1[57:29], d0[28:0]}));
        do_write(8'd7, 3'b011, d1);
        do_read(8'd7, "t2_repl_only");

        // Prefill every set with valid and fifo bits set
        for (int i = 0; i < SETS; i++) do_write(IDX_W'(i), 3'b000, rnd_word() | ~keep);

        // T5 read together with inv_req, then T3/T4 sweep timing
        cen_b = 1'b0; wen = 3'b111; index = 8'd3; inv_req = 1'b1;
        exp_q.push_back(model[3]);
        tick();
        idle_in();
        held = exp_q.pop_front();
        check("t5_same_cycle_read", 64'(dout), 64'(held));
        check("t3_busy_cycle1", 64'(busy), 64'd1);
        cyc = 1; busy_cnt = 0; done_cyc = 0;
        while (done_cyc == 0 && cyc < 400) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cyc = cyc;
            end else begin
                idle_in();
                if (cyc == 10) begin
                    cen_b = 1'b0; wen = 3'b000; index = 8'd20; din = rnd_word();
                end
                if (cyc == 30) begin
                    cen_b = 1'b0; wen = 3'b111; index = 8'd40;
                end
                if (cyc == 50) inv_req = 1'b1;
                tick();
                cyc++;
            end
        end
        idle_in();
        check("t3_done_cycle", 64'(done_cyc), 64'd257);
        check("t3_busy_cycles", 64'(busy_cnt), 64'd256);
        check("t3_busy_at_done", 64'(busy), 64'd0);
        check("t4_dout_held", 64'(dout), 64'(held));
        for (int i = 0; i < SETS; i++) model[i] = model[i] & keep;
        tick();
        check("t3_done_width", 64'(done), 64'd0);
        check("t3_idle_busy", 64'(busy), 64'd0);
        for (int i = 0; i < SETS; i++) do_read(IDX_W'(i), "t3_swept_set");

        // T6 reset in the middle of a sweep
        for (int i = 0; i < 128; i++) do_write(IDX_W'(i), 3'b000, rnd_word() | ~keep);
        do_read(8'd120, "t6_preload");
        inv_req = 1'b1;
        tick();
        idle_in();
        repeat (99) tick();
        check("t6_busy_before_rst", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_done", 64'(done), 64'd0);
        check("t6_rst_dout", 64'(dout), 64'd0);
        for (int i = 0; i < 99; i++) model[i] = model[i] & keep;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_no_resume", 64'({busy, done}), 64'd0);
        end
        for (int i = 0; i < 99; i++) do_read(IDX_W'(i), "t6_cleared_set");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
